// File: rtl/img2col_pkg.sv
// img2col_pkg: shared types, default sizes and configuration check for the img2col streaming front-end
package img2col_pkg;
    localparam int DATA_W_D = 8;
    localparam int MAX_W_D = 32;
    localparam int MAX_H_D = 32;
    localparam int K_MAX_D = 5;
    localparam int KW = $clog2(K_MAX_D + 1);
    localparam int WW = $clog2(MAX_W_D + 1);
    localparam int HW = $clog2(MAX_H_D + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef struct packed {
        logic [KW-1:0] k;
        logic stride;
        logic [WW-1:0] w;
        logic [HW-1:0] h;
    } cfg_t;
    function automatic logic cfg_legal(cfg_t c, int k_max, int max_w, int max_h);
        return int'(c.k) != 0 && int'(c.k) <= k_max && int'(c.k) <= int'(c.w) &&
               int'(c.k) <= int'(c.h) && int'(c.w) <= max_w && int'(c.h) <= max_h;
    endfunction
endpackage

// File: rtl/img2col_line_buf.sv
// img2col_line_buf: K_MAX-1 rotating line stores; every stored row is read at the current column
module img2col_line_buf #(
    parameter int DATA_W = 8,
    parameter int MAX_W = 32,
    parameter int K_MAX = 5
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic we,
    input  logic adv,
    input  logic [$clog2(MAX_W)-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] rows [K_MAX-1]
);
    localparam int NR = K_MAX - 1;
    localparam int PW = NR > 1 ? $clog2(NR) : 1;
    logic [DATA_W-1:0] mem [NR][MAX_W];
    logic [PW-1:0] wp;
    always_ff @(posedge clk) begin
        if (nrst || clr) wp <= '0;
        else if (adv) wp <= int'(wp) == NR - 1 ? '0 : wp + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (we) mem[wp][addr] <= din;
    end
    // rows[d] is image row r-1-d; the slot being written still holds the oldest row until the edge
    always_comb begin
        for (int d = 0; d < NR; d++) rows[d] = mem[PW'((int'(wp) + NR - 1 - d) % NR)][addr];
    end
endmodule

// File: rtl/img2col_stream.sv
// img2col_stream: streaming im2col front-end; buffers k-1 lines and emits one flattened kxk window
// per valid output position, with valid/ready on both sides
module img2col_stream
    import img2col_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int MAX_W = MAX_W_D,
    parameter int MAX_H = MAX_H_D,
    parameter int K_MAX = K_MAX_D
) (
    input  logic clk,
    input  logic nrst,
    input  logic start,
    input  logic [$clog2(K_MAX+1)-1:0] cfg_k,
    input  logic cfg_stride,
    input  logic [$clog2(MAX_W+1)-1:0] cfg_w,
    input  logic [$clog2(MAX_H+1)-1:0] cfg_h,
    input  logic in_valid,
    output logic in_ready,
    input  logic [DATA_W-1:0] in_pix,
    output logic out_valid,
    input  logic out_ready,
    output logic [DATA_W*K_MAX*K_MAX-1:0] out_win,
    output logic out_last,
    output logic busy,
    output logic done,
    output logic cfg_err
);
    localparam int AW = $clog2(MAX_W);
    localparam int PW = K_MAX > 2 ? $clog2(K_MAX - 1) : 1;
    state_e state;
    cfg_t cfg, cfg_in;
    logic [WW-1:0] c;
    logic [HW-1:0] r;
    logic all_in, last_sent, acc, emit, is_last, end_col, end_px, last_hs, hold;
    logic [DATA_W-1:0] rows [K_MAX-1];
    logic [DATA_W-1:0] col [K_MAX];
    logic [DATA_W*K_MAX*K_MAX-1:0] win_nxt;
    int kk, rr, cc, ww, hh;
    assign cfg_in = '{k: KW'(cfg_k), stride: cfg_stride, w: WW'(cfg_w), h: HW'(cfg_h)};
    assign kk = int'(cfg.k);
    assign ww = int'(cfg.w);
    assign hh = int'(cfg.h);
    assign rr = int'(r);
    assign cc = int'(c);
    assign hold = out_valid && !out_ready;
    assign in_ready = state == RUN && !all_in && !hold;
    assign acc = in_valid && in_ready;
    assign last_hs = out_valid && out_ready && out_last;
    assign end_col = cc == ww - 1;
    assign end_px = end_col && rr == hh - 1;
    assign emit = acc && rr >= kk - 1 && cc >= kk - 1 &&
                  (!cfg.stride || ((rr - kk + 1) % 2 == 0 && (cc - kk + 1) % 2 == 0));
    // stride 2 leaves a trailing row/column unused when (size-k) is odd
    assign is_last = rr == hh - 1 - (cfg.stride ? (hh - kk) % 2 : 0) &&
                     cc == ww - 1 - (cfg.stride ? (ww - kk) % 2 : 0);
    img2col_line_buf #(.DATA_W(DATA_W), .MAX_W(MAX_W), .K_MAX(K_MAX)) u_line_buf (
        .clk(clk),
        .nrst(nrst),
        .clr(state != RUN),
        .we(acc && kk > 1),
        .adv(acc && end_col),
        .addr(c[AW-1:0]),
        .din(in_pix),
        .rows(rows)
    );
    always_comb begin
        for (int i = 0; i < K_MAX; i++) begin
            col[i] = '0;
            if (i == kk - 1) col[i] = in_pix;
            else if (i < kk - 1) col[i] = rows[PW'(kk - 2 - i)];
        end
    end
    // shift the window left one column and load the new column at j=k-1; j>=k stays zero
    always_comb begin
        win_nxt = '0;
        for (int i = 0; i < K_MAX; i++) begin
            for (int j = 0; j < K_MAX - 1; j++)
                if (j < kk - 1) win_nxt[(i*K_MAX+j)*DATA_W +: DATA_W] = out_win[(i*K_MAX+j+1)*DATA_W +: DATA_W];
            for (int j = 0; j < K_MAX; j++)
                if (j == kk - 1) win_nxt[(i*K_MAX+j)*DATA_W +: DATA_W] = col[i];
        end
    end
    always_ff @(posedge clk) begin
        if (nrst) begin
            state <= IDLE;
            cfg <= '0;
            r <= '0;
            c <= '0;
            all_in <= 1'b0;
            last_sent <= 1'b0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_win <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (cfg_legal(cfg_in, K_MAX, MAX_W, MAX_H)) begin
                        state <= RUN;
                        cfg <= cfg_in;
                        busy <= 1'b1;
                        r <= '0;
                        c <= '0;
                        all_in <= 1'b0;
                        last_sent <= 1'b0;
                        out_win <= '0;
                    end else cfg_err <= 1'b1;
                end
                RUN: begin
                    if (acc) begin
                        c <= end_col ? '0 : c + 1'b1;
                        r <= end_col ? r + 1'b1 : r;
                        all_in <= end_px;
                        out_win <= win_nxt;
                    end
                    out_valid <= emit || hold;
                    out_last <= emit ? is_last : hold && out_last;
                    last_sent <= last_sent || last_hs;
                    if ((last_sent || last_hs) && (all_in || (acc && end_px))) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_img2col_stream.sv
// tb_img2col_stream: table-driven and randomized frames checked against a direct im2col reference
module tb_img2col_stream;
    localparam int DW = 8;
    localparam int KM = 5;
    localparam int OW = DW * KM * KM;
    typedef struct {
        int k;
        int s;
        int w;
        int h;
        int rnd;
        int stall;
        int hold_at;
        int exp_n;
    } vec_t;
    logic clk = 1'b0;
    logic nrst, start, cfg_stride, in_valid, in_ready, out_valid, out_ready, out_last, busy, done, cfg_err;
    logic [2:0] cfg_k;
    logic [5:0] cfg_w, cfg_h;
    logic [DW-1:0] in_pix;
    logic [OW-1:0] out_win;
    logic [DW-1:0] img [32][32];
    logic [OW-1:0] exp_win [$];
    bit exp_last [$];
    vec_t tv [7];
    int n_chk = 0;
    int n_fail = 0;
    img2col_stream dut (
        .clk(clk), .nrst(nrst), .start(start), .cfg_k(cfg_k), .cfg_stride(cfg_stride),
        .cfg_w(cfg_w), .cfg_h(cfg_h), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win), .out_last(out_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // reference: every output position enumerated directly from the stored image
    task automatic build_exp(input int k, input int s, input int w, input int h);
        int st, nr, nc;
        st = s ? 2 : 1;
        nr = (h - k) / st + 1;
        nc = (w - k) / st + 1;
        exp_win.delete();
        exp_last.delete();
        for (int oi = 0; oi < nr; oi++)
            for (int oj = 0; oj < nc; oj++) begin
                logic [OW-1:0] v;
                v = '0;
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++) v[(i*KM+j)*DW +: DW] = img[oi*st+i][oj*st+j];
                exp_win.push_back(v);
                exp_last.push_back(oi == nr - 1 && oj == nc - 1);
            end
    endtask
    task automatic run_frame(input int t, input int k, input int s, input int w, input int h,
                             input int rnd, input int stall, input int hold_at, input int exp_n);
        int pi, got, cyc, hold;
        bit fin, prev_stall, prev_last;
        logic [OW-1:0] prev_win;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) img[r][c] = rnd ? 8'($urandom) : 8'(r * w + c);
        build_exp(k, s, w, h);
        @(negedge clk);
        cfg_k = 3'(k);
        cfg_stride = s[0];
        cfg_w = 6'(w);
        cfg_h = 6'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk($sformatf("t%0d_busy", t), busy, 1);
        pi = 0; got = 0; cyc = 0; hold = 0; fin = 0; prev_stall = 0; prev_last = 0; prev_win = '0;
        while (!fin) begin
            @(negedge clk);
            in_valid = pi < w * h && $urandom_range(99) >= stall;
            in_pix = '0;
            if (in_valid) in_pix = img[pi / w][pi % w];
            out_ready = hold > 0 ? 1'b0 : $urandom_range(99) >= stall;
            if (hold > 0) hold--;
            #1;
            if (prev_stall) begin
                chk($sformatf("t%0d_hold_valid", t), out_valid, 1);
                chk($sformatf("t%0d_hold_win", t), out_win, prev_win);
                chk($sformatf("t%0d_hold_last", t), out_last, prev_last);
            end
            if (out_valid && !out_ready) chk($sformatf("t%0d_bp_in_ready", t), in_ready, 0);
            if (in_valid && in_ready) pi++;
            if (out_valid && out_ready) begin
                if (got < exp_win.size()) begin
                    chk($sformatf("t%0d_win%0d", t, got), out_win, exp_win[got]);
                    chk($sformatf("t%0d_last%0d", t, got), out_last, exp_last[got]);
                end else chk($sformatf("t%0d_extra_win", t), got, exp_win.size());
                got++;
                if (got == hold_at) hold = 10;
            end
            prev_stall = out_valid && !out_ready;
            prev_win = out_win;
            prev_last = out_last;
            if (done) fin = 1;
            if (++cyc > 20000) begin
                n_chk++;
                n_fail++;
                $display("FAIL t%0d_timeout: got %0d windows %0d pixels, required done", t, got, pi);
                fin = 1;
            end
        end
        in_valid = 1'b0;
        chk($sformatf("t%0d_count", t), got, exp_n);
        chk($sformatf("t%0d_pixels", t), pi, w * h);
        @(negedge clk);
        #1;
        chk($sformatf("t%0d_done_pulse", t), done, 0);
        chk($sformatf("t%0d_busy_end", t), busy, 0);
    endtask
    initial begin
        tv[0] = '{3, 0, 5, 5, 0, 0, -1, 9};
        tv[1] = '{3, 1, 5, 5, 0, 0, -1, 4};
        tv[2] = '{3, 1, 7, 7, 0, 20, -1, 9};
        tv[3] = '{5, 0, 5, 5, 0, 0, -1, 1};
        tv[4] = '{3, 0, 8, 6, 1, 0, 6, 24};
        tv[5] = '{1, 1, 4, 4, 0, 0, -1, 4};
        tv[6] = '{4, 1, 13, 11, 1, 25, 3, 20};
        nrst = 1'b1; start = 1'b0; cfg_k = '0; cfg_stride = 1'b0; cfg_w = '0; cfg_h = '0;
        in_valid = 1'b0; in_pix = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_win", out_win, 0);
        chk("rst_flags", {out_last, busy, done, cfg_err}, 0);
        nrst = 1'b0;
        for (int t = 0; t < 7; t++)
            run_frame(t, tv[t].k, tv[t].s, tv[t].w, tv[t].h, tv[t].rnd, tv[t].stall, tv[t].hold_at, tv[t].exp_n);
        // illegal configurations: k > w, then k == 0
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            cfg_k = e == 0 ? 3'd4 : 3'd0;
            cfg_w = e == 0 ? 6'd3 : 6'd5;
            cfg_h = 6'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            chk($sformatf("err%0d_pulse", e), cfg_err, 1);
            chk($sformatf("err%0d_busy", e), busy, 0);
            @(negedge clk);
            #1;
            chk($sformatf("err%0d_pulse_end", e), cfg_err, 0);
            chk($sformatf("err%0d_busy_after", e), busy, 0);
        end
        // abandon a frame after 12 pixels with reset
        @(negedge clk);
        cfg_k = 3'd3; cfg_stride = 1'b0; cfg_w = 6'd5; cfg_h = 6'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_pix = 8'(i + 100);
            out_ready = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("mid_busy_before", busy, 1);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_win", out_win, 0);
        chk("mid_rst_flags", {out_last, busy, done, cfg_err}, 0);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_idle_in_ready", in_ready, 0);
        run_frame(10, 3, 0, 5, 5, 0, 0, -1, 9);
        for (int n = 0; n < 4; n++) begin
            int k, s, w, h;
            k = $urandom_range(1, 5);
            s = $urandom_range(0, 1);
            w = $urandom_range(k, 12);
            h = $urandom_range(k, 12);
            run_frame(20 + n, k, s, w, h, 1, 30, 2, ((h - k) / (s + 1) + 1) * ((w - k) / (s + 1) + 1));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
